// File: rtl/sram_l128d128_ctrl.sv
// sram_l128d128_ctrl: valid/ready front end for a 128x128 bit-masked SRAM macro with zero-fill after reset
module sram_l128d128_ctrl #(
  parameter int DEPTH = 128,
  parameter int AW = 7,
  parameter int DW = 128,
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wen,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [SW-1:0] req_wstrb,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          init_done,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [DW-1:0] sram_bwen,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic resp_valid_q, resp_valid_d, from_q_q, from_q_d;
  logic [DW-1:0] hold_q, hold_d, strb_mask;
  logic init, run, rd_acc;
  for (genvar g = 0; g < SW; g++) begin : g_mask
    assign strb_mask[8*g +: 8] = {8{req_wstrb[g]}};
  end
  assign init = !rst && state_q == INIT;
  assign run = !rst && state_q == RUN;
  assign init_done = run;
  assign req_ready = run && !(resp_valid_q && !resp_ready);
  assign resp_valid = !rst && resp_valid_q;
  // Q is only meaningful the cycle after a read; afterwards the hold register carries it
  assign resp_rdata = from_q_q ? sram_q : hold_q;
  assign rd_acc = req_valid && req_ready && !req_wen;
  assign sram_cen = init ? 1'b0 : !(req_valid && req_ready);
  assign sram_wen = init ? 1'b0 : run ? !req_wen : 1'b1;
  assign sram_bwen = init ? '0 : (run && req_wen) ? ~strb_mask : '1;
  assign sram_a = init ? cnt_q : req_addr;
  assign sram_d = run ? req_wdata : '0;
  always_comb begin
    state_d = (state_q == INIT && cnt_q == AW'(DEPTH - 1)) ? RUN : state_q;
    cnt_d = (state_q == INIT) ? cnt_q + 1'b1 : cnt_q;
    resp_valid_d = rd_acc || (resp_valid_q && !resp_ready);
    from_q_d = rd_acc;
    hold_d = (from_q_q && resp_valid_q && !resp_ready) ? sram_q : hold_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q <= '0;
      resp_valid_q <= 1'b0;
      from_q_q <= 1'b0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      resp_valid_q <= resp_valid_d;
      from_q_q <= from_q_d;
      hold_q <= hold_d;
    end
  end
endmodule

// File: tb/tb_sram_l128d128_ctrl.sv
// tb_sram_l128d128_ctrl: directed and randomized checks against a byte-level memory model and a macro model
module tb_sram_l128d128_ctrl;
  localparam int DEPTH = 128;
  localparam int AW = 7;
  localparam int DW = 128;
  localparam int SW = 16;
  logic clk = 0;
  logic rst = 1;
  logic req_valid = 0, req_wen = 0, resp_ready = 1;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_wstrb = '0;
  logic req_ready, resp_valid, init_done, sram_cen, sram_wen;
  logic [DW-1:0] resp_rdata, sram_bwen, sram_d, sram_q;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic seeded = 0;
  int checks = 0, passes = 0;

  sram_l128d128_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .init_done(init_done), .sram_cen(sram_cen),
    .sram_wen(sram_wen), .sram_bwen(sram_bwen), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic [DW-1:0] r = old;
    for (int i = 0; i < SW; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Macro model: array starts as garbage, Q is random unless a read happened last cycle
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= rnd128();
      seeded <= 1;
    end else if (!sram_cen && !sram_wen)
      mem[sram_a] <= (mem[sram_a] & sram_bwen) | (sram_d & ~sram_bwen);
    sram_q <= (!sram_cen && sram_wen && seeded) ? mem[sram_a] : rnd128();
  end

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid = v; req_wen = w; req_addr = a; req_wdata = d; req_wstrb = s;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic zero_fill();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 0 || sram_cen !== 0 || sram_wen !== 0 || sram_bwen !== '0 || sram_a !== AW'(i) || init_done !== 0)
        $display("FAIL init_cycle%0d: ready=%b cen=%b wen=%b a=%0d done=%b bwen=%h, want 0 0 0 %0d 0 0", i, req_ready, sram_cen, sram_wen, sram_a, init_done, sram_bwen, i);
      else passes++;
      tick();
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    drive(1, 1, a, d, s);
    @(negedge clk);
    checks++;
    if (req_ready !== 1 || sram_cen !== 0 || sram_wen !== 0) $display("FAIL wr_accept: ready=%b cen=%b wen=%b want 1 0 0", req_ready, sram_cen, sram_wen);
    else passes++;
    tick();
    ref_mem[a] = merge(ref_mem[a], d, s);
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] got);
    resp_ready = 1;
    drive(1, 0, a, 0, 0);
    @(negedge clk);
    checks++;
    if (req_ready !== 1 || sram_cen !== 0 || sram_wen !== 1 || sram_a !== a) $display("FAIL rd_accept: ready=%b cen=%b wen=%b a=%0d want 1 0 1 %0d", req_ready, sram_cen, sram_wen, sram_a, a);
    else passes++;
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    got = resp_rdata;
    checks++;
    if (resp_valid !== 1 || resp_rdata !== ref_mem[a]) $display("FAIL rd_data a=%0d: valid=%b got %h want %h", a, resp_valid, resp_rdata, ref_mem[a]);
    else passes++;
    tick();
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    rst = 1;
    drive(1, 0, 5, 0, 0);
    @(negedge clk);
    checks++;
    if (req_ready !== 0 || resp_valid !== 0 || init_done !== 0 || sram_cen !== 1 || sram_wen !== 1 || sram_bwen !== '1)
      $display("FAIL reset_state: ready=%b rvalid=%b done=%b cen=%b wen=%b bwen=%h", req_ready, resp_valid, init_done, sram_cen, sram_wen, sram_bwen);
    else passes++;
    tick();
    rst = 0;
    zero_fill();
    @(negedge clk);
    checks++;
    if (init_done !== 1 || req_ready !== 1 || sram_cen !== 0 || sram_wen !== 1 || sram_a !== 5)
      $display("FAIL run_entry: done=%b ready=%b cen=%b wen=%b a=%0d want 1 1 0 1 5", init_done, req_ready, sram_cen, sram_wen, sram_a);
    else passes++;
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    d = resp_rdata;
    checks++;
    if (resp_valid !== 1 || d !== '0) $display("FAIL first_read: valid=%b data=%h want 1 0", resp_valid, d);
    else passes++;
    tick();
    @(negedge clk);
    checks++;
    if (resp_valid !== 0) $display("FAIL resp_clear: valid=%b want 0", resp_valid);
    else passes++;
  endtask

  task automatic test_strobe();
    logic [DW-1:0] d;
    wr(3, 128'h0011_2233, 16'h0001);
    rd(3, d);
    checks++;
    if (d !== 128'h33) $display("FAIL strobe_byte0: got %h want 33", d);
    else passes++;
  endtask

  task automatic test_bytemask();
    logic [DW-1:0] d;
    wr(7, '1, 16'hFFFF);
    drive(1, 1, 7, '0, 16'h00F0);
    @(negedge clk);
    checks++;
    if (sram_bwen !== 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF || sram_cen !== 0 || sram_wen !== 0)
      $display("FAIL bwen_mask: bwen=%h cen=%b wen=%b", sram_bwen, sram_cen, sram_wen);
    else passes++;
    tick();
    ref_mem[7] = merge(ref_mem[7], '0, 16'h00F0);
    drive(0, 0, 0, 0, 0);
    rd(7, d);
    checks++;
    if (d !== 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF) $display("FAIL bytes4_7_cleared: got %h", d);
    else passes++;
    wr(7, rnd128(), 16'h0000);
    rd(7, d);
    checks++;
    if (d !== 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF) $display("FAIL zero_strobe: got %h", d);
    else passes++;
  endtask

  task automatic test_back_to_back();
    for (int a = 1; a <= 3; a++) wr(AW'(a), rnd128(), 16'hFFFF);
    resp_ready = 1;
    for (int k = 0; k <= 4; k++) begin
      if (k < 3) drive(1, 0, AW'(k + 1), 0, 0);
      else drive(0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (k < 3 && req_ready !== 1) $display("FAIL b2b_ready%0d: got %b want 1", k, req_ready);
      else if (k >= 1 && k <= 3 && (resp_valid !== 1 || resp_rdata !== ref_mem[k]))
        $display("FAIL b2b_data%0d: valid=%b got %h want %h", k, resp_valid, resp_rdata, ref_mem[k]);
      else if ((k == 0 || k == 4) && resp_valid !== 0) $display("FAIL b2b_idle%0d: valid=%b want 0", k, resp_valid);
      else passes++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] pat = {16{8'hA5}};
    logic [DW-1:0] d;
    wr(9, pat, 16'hFFFF);
    resp_ready = 0;
    drive(1, 0, 9, 0, 0);
    tick();
    drive(1, 1, 9, rnd128(), 16'hFFFF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1 || resp_rdata !== pat || req_ready !== 0 || sram_cen !== 1)
        $display("FAIL stall%0d: valid=%b data=%h ready=%b cen=%b", k, resp_valid, resp_rdata, req_ready, sram_cen);
      else passes++;
      tick();
    end
    resp_ready = 1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1 || resp_rdata !== pat || req_ready !== 1) $display("FAIL stall_release: valid=%b data=%h ready=%b", resp_valid, resp_rdata, req_ready);
    else passes++;
    tick();
    @(negedge clk);
    checks++;
    if (resp_valid !== 0) $display("FAIL stall_clear: valid=%b want 0", resp_valid);
    else passes++;
    rd(9, d);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    resp_ready = 0;
    drive(1, 0, 9, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    rst = 1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 0 || init_done !== 0 || req_ready !== 0 || sram_cen !== 1)
      $display("FAIL mid_reset: valid=%b done=%b ready=%b cen=%b", resp_valid, init_done, req_ready, sram_cen);
    else passes++;
    tick();
    rst = 0;
    resp_ready = 1;
    zero_fill();
    rd(9, d);
    checks++;
    if (d !== '0) $display("FAIL refill_read: got %h want 0", d);
    else passes++;
  endtask

  task automatic test_random();
    logic pend = 0;
    logic [DW-1:0] pend_data = '0;
    logic exp_ready;
    for (int n = 0; n < 600; n++) begin
      resp_ready = 1'($urandom_range(0, 2) != 0);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom_range(0, 15)), rnd128(),
            ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom));
      @(negedge clk);
      exp_ready = !(pend && !resp_ready);
      checks++;
      if (req_ready !== exp_ready || resp_valid !== pend || (pend && resp_rdata !== pend_data))
        $display("FAIL rand%0d: ready=%b valid=%b data=%h want %b %b %h", n, req_ready, resp_valid, resp_rdata, exp_ready, pend, pend_data);
      else passes++;
      if (req_valid && exp_ready && !req_wen) begin
        pend = 1;
        pend_data = ref_mem[req_addr];
      end else if (pend && resp_ready) pend = 0;
      if (req_valid && exp_ready && req_wen) ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_wstrb);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    resp_ready = 1;
    tick();
  endtask

  initial begin
    test_reset();
    tick();
    test_strobe();
    test_bytemask();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
